ram16k_arbiter: RTL and testbench

//  Two-port round-robin arbiter/sequencer in front of the 16K-word data RAM.

---
 rtl/memory_pkg.sv | 15 +
 rtl/rr_arb2.sv | 35 +++
 rtl/ram16k_arbiter.sv | 116 +++++++++++
 tb/tb_ram16k_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared widths and request types for the data RAM arbiter
package memory_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 14;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

  typedef logic port_id_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker, combinational
module rr_arb2
  import memory_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   rr_last,
  output logic [1:0] gnt,
  output port_id_t   gnt_id
);

  // A lone requester always wins; on a tie the port that did not win last time goes.
  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    unique case (req)
      2'b01: begin
        gnt    = 2'b01;
        gnt_id = 1'b0;
      end
      2'b10: begin
        gnt    = 2'b10;
        gnt_id = 1'b1;
      end
      2'b11: begin
        gnt_id = ~rr_last;
        gnt    = rr_last ? 2'b01 : 2'b10;
      end
      default: begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ram16k_arbiter.sv
// rtl/ram16k_arbiter.sv - CPU/DMA round-robin sequencer in front of the 16K-word data RAM
module ram16k_arbiter #(
  parameter int WORD_W = memory_pkg::WORD_W,
  parameter int ADDR_W = memory_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [WORD_W-1:0] req_wdata0,
  input  logic [WORD_W-1:0] req_wdata1,
  output logic [1:0]        rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [WORD_W-1:0] ram_out,
  output logic [CNT_W-1:0]  conflict_cnt
);

  import memory_pkg::port_id_t;

  logic [1:0]        gnt;
  port_id_t          gnt_id;
  port_id_t          rr_last;
  logic              grant;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [WORD_W-1:0] sel_wdata;

  logic              acc_vld;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  port_id_t          acc_owner;

  rr_arb2 u_rr_arb2 (
    .req     (req_valid),
    .rr_last (rr_last),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  // Accept nothing while reset is held so that every output reads zero during reset.
  always_comb begin
    req_ready = gnt & {2{rst_n}};
    grant     = |gnt;
    sel_we    = gnt_id ? req_we[1]  : req_we[0];
    sel_addr  = gnt_id ? req_addr1  : req_addr0;
    sel_wdata = gnt_id ? req_wdata1 : req_wdata0;
  end

  // ACC stage: capture the granted request; address/data hold when no grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_vld   <= 1'b0;
      acc_we    <= 1'b0;
      acc_addr  <= '0;
      acc_wdata <= '0;
      acc_owner <= 1'b0;
    end else if (grant) begin
      acc_vld   <= 1'b1;
      acc_we    <= sel_we;
      acc_addr  <= sel_addr;
      acc_wdata <= sel_wdata;
      acc_owner <= gnt_id;
    end else begin
      acc_vld   <= 1'b0;
    end
  end

  // RAM is driven straight from ACC; write strobe only for a live write.
  always_comb begin
    ram_addr = acc_addr;
    ram_in   = acc_wdata;
    ram_load = acc_vld & acc_we;
  end

  // Response register: writes echo their data, reads take the RAM output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 2'b00;
      if (acc_vld) begin
        rsp_valid[acc_owner] <= 1'b1;
        rsp_rdata            <= acc_we ? acc_wdata : ram_out;
      end
    end
  end

  // Remember the last winner; reset value 1 lets port 0 take the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b1;
    end else if (grant) begin
      rr_last <= gnt_id;
    end
  end

  // Count cycles where both masters compete, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if ((&req_valid) && !(&conflict_cnt)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ram16k_arbiter.sv
// tb/tb_ram16k_arbiter.sv - directed self-checking bench for ram16k_arbiter
`timescale 1ns/1ps
module tb_ram16k_arbiter;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 14;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_we;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [WORD_W-1:0] req_wdata0;
  logic [WORD_W-1:0] req_wdata1;
  logic [1:0]        rsp_valid;
  logic [WORD_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_in;
  logic              ram_load;
  logic [WORD_W-1:0] ram_out;
  logic [CNT_W-1:0]  conflict_cnt;

  logic [WORD_W-1:0] mem [0:16383];

  int checks;
  int errors;

  ram16k_arbiter #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr0    (req_addr0),
    .req_addr1    (req_addr1),
    .req_wdata0   (req_wdata0),
    .req_wdata1   (req_wdata1),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .ram_addr     (ram_addr),
    .ram_in       (ram_in),
    .ram_load     (ram_load),
    .ram_out      (ram_out),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, write on the rising edge.
  assign ram_out = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_load) mem[ram_addr] <= ram_in;
  end

  task automatic idle_inputs();
    req_valid  = 2'b00;
    req_we     = 2'b00;
    req_addr0  = '0;
    req_addr1  = '0;
    req_wdata0 = '0;
    req_wdata1 = '0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_rdata, ram_addr, ram_in, ram_load, conflict_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: rsp_valid=%b rsp_rdata=%h ram_addr=%h ram_in=%h ram_load=%b cnt=%h, required all zero",
               rsp_valid, rsp_rdata, ram_addr, ram_in, ram_load, conflict_cnt);
    end
    rst_n     = 1'b1;
    mem[16'h0010] = 16'hA0A0;
    mem[16'h0020] = 16'hB0B0;
    req_addr0 = 14'h0010;
    req_addr1 = 14'h0020;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL first_tie: req_ready=%b required 01", req_ready);
    end
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, ram_addr, ram_in, ram_load, conflict_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset: req_ready=%b rsp_valid=%b rsp_rdata=%h ram_addr=%h ram_in=%h ram_load=%b cnt=%h, required all zero",
               req_ready, rsp_valid, rsp_rdata, ram_addr, ram_in, ram_load, conflict_cnt);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    mem[16'h0123] = 16'hBEEF;
    @(posedge clk); #1;
    req_valid = 2'b01;
    req_we    = 2'b00;
    req_addr0 = 14'h0123;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ready: req_ready=%b required 01", req_ready);
    end
    @(posedge clk); #1;
    idle_inputs();
    #1;
    checks++;
    if (ram_addr !== 14'h0123 || ram_load !== 1'b0 || rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL single_acc: ram_addr=%h ram_load=%b rsp_valid=%b required 0123 0 00", ram_addr, ram_load, rsp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL single_rsp: rsp_valid=%b rsp_rdata=%h required 01 beef", rsp_valid, rsp_rdata);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL single_pulse: rsp_valid=%b required 00", rsp_valid);
    end
  endtask

  task automatic test_contention();
    int cnt0;
    int cnt1;
    cnt0 = 0;
    cnt1 = 0;
    pulse_reset();
    req_addr0 = 14'h0010;
    req_addr1 = 14'h0020;
    req_we    = 2'b00;
    req_valid = 2'b11;
    for (int i = 0; i < 12; i++) begin
      if (i == 8) idle_inputs();
      if (rsp_valid == 2'b01) begin
        cnt0++;
        checks++;
        if (rsp_rdata !== 16'hA0A0) begin
          errors++;
          $display("FAIL cont_rdata0: cycle %0d rsp_rdata=%h required a0a0", i, rsp_rdata);
        end
      end else if (rsp_valid == 2'b10) begin
        cnt1++;
        checks++;
        if (rsp_rdata !== 16'hB0B0) begin
          errors++;
          $display("FAIL cont_rdata1: cycle %0d rsp_rdata=%h required b0b0", i, rsp_rdata);
        end
      end
      if (i < 8) begin
        #1;
        checks++;
        if (req_ready !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL cont_grant: cycle %0d req_ready=%b required %b", i, req_ready,
                   ((i % 2 == 1) ? 2'b10 : 2'b01));
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (cnt0 != 4 || cnt1 != 4) begin
      errors++;
      $display("FAIL cont_rsp_count: port0=%0d port1=%0d required 4 4", cnt0, cnt1);
    end
    checks++;
    if (conflict_cnt !== 4'd8) begin
      errors++;
      $display("FAIL cont_conflict_cnt: conflict_cnt=%0d required 8", conflict_cnt);
    end
  endtask

  task automatic test_raw();
    mem[16'h3FFF] = 16'h0000;
    @(posedge clk); #1;
    req_valid  = 2'b10;
    req_we     = 2'b10;
    req_addr1  = 14'h3FFF;
    req_wdata1 = 16'h1234;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL raw_wr_ready: req_ready=%b required 10", req_ready);
    end
    @(posedge clk); #1;
    req_we     = 2'b00;
    req_wdata1 = 16'h5555;
    #1;
    checks++;
    if (req_ready !== 2'b10 || ram_load !== 1'b1 || ram_addr !== 14'h3FFF || ram_in !== 16'h1234) begin
      errors++;
      $display("FAIL raw_wr_stage: ready=%b ram_load=%b ram_addr=%h ram_in=%h required 10 1 3fff 1234",
               req_ready, ram_load, ram_addr, ram_in);
    end
    @(posedge clk); #1;
    idle_inputs();
    checks++;
    if (rsp_valid !== 2'b10 || rsp_rdata !== 16'h1234 || mem[16'h3FFF] !== 16'h1234) begin
      errors++;
      $display("FAIL raw_wr_rsp: rsp_valid=%b rsp_rdata=%h mem=%h required 10 1234 1234",
               rsp_valid, rsp_rdata, mem[16'h3FFF]);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 2'b10 || rsp_rdata !== 16'h1234) begin
      errors++;
      $display("FAIL raw_rd_rsp: rsp_valid=%b rsp_rdata=%h required 10 1234", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_saturation();
    pulse_reset();
    req_addr0 = 14'h0010;
    req_addr1 = 14'h0020;
    req_valid = 2'b11;
    for (int i = 1; i <= 21; i++) begin
      @(posedge clk); #1;
      if (i == 14) begin
        checks++;
        if (conflict_cnt !== 4'hE) begin
          errors++;
          $display("FAIL sat_14: conflict_cnt=%h required e", conflict_cnt);
        end
      end
      if (i == 15 || i == 16 || i == 21) begin
        checks++;
        if (conflict_cnt !== 4'hF) begin
          errors++;
          $display("FAIL sat_hold: after %0d cycles conflict_cnt=%h required f", i, conflict_cnt);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_write();
    mem[16'h0055] = 16'h1111;
    @(posedge clk); #1;
    req_valid  = 2'b01;
    req_we     = 2'b01;
    req_addr0  = 14'h0055;
    req_wdata0 = 16'h2222;
    @(posedge clk); #1;
    idle_inputs();
    #1;
    checks++;
    if (ram_load !== 1'b1) begin
      errors++;
      $display("FAIL rstwr_load_before: ram_load=%b required 1", ram_load);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ram_load !== 1'b0 || ram_addr !== 14'h0000 || ram_in !== 16'h0000) begin
      errors++;
      $display("FAIL rstwr_async: ram_load=%b ram_addr=%h ram_in=%h required 0 0000 0000", ram_load, ram_addr, ram_in);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 2'b00 || mem[16'h0055] !== 16'h1111) begin
      errors++;
      $display("FAIL rstwr_no_effect: rsp_valid=%b mem=%h required 00 1111", rsp_valid, mem[16'h0055]);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 2'b00 || mem[16'h0055] !== 16'h1111) begin
      errors++;
      $display("FAIL rstwr_after: rsp_valid=%b mem=%h required 00 1111", rsp_valid, mem[16'h0055]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_raw();
    test_saturation();
    test_reset_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
